scroll_msg_loader: RTL and testbench
====================================

SCROLL_MSG_LOADER -- requirements
Module: scroll_msg_loader

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000, number of consecutive stable clocks (10 ms at 50 MHz) before a key level is accepted.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port seg_in  input  7 ([0:6])  active-low segment code to store (0 = segment lit).
REQ-005 SHALL have port wr_key_n  input  1  raw active-low pushbutton, append character.
REQ-006 SHALL have port clr_key_n  input  1  raw active-low pushbutton, clear message.
REQ-007 SHALL have port rd_req  input  1  one-cycle request from scroller for next character.
REQ-008 SHALL have port rd_data  output  7 ([0:6])  character returned to scroller.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-010 SHALL have port msg_len  output  4  stored character count, 0..8.
REQ-011 SHALL have ports full and empty  output  1 each  msg_len==8 and msg_len==0.
REQ-012 SHALL have ports wr_ack and ovf  output  1 each  one-cycle pulses: write accepted / write dropped.

Function
REQ-013 SHALL pass each raw key through a 2-flop synchronizer before use.
REQ-014 SHALL keep one debounce counter per key; debounced level updates only after synchronized level differs from it for DB_CYCLES consecutive clocks; any reversion restarts count at 0.
REQ-015 SHALL generate one press event per debounced 1->0 transition; holding a key SHALL produce no further events; release SHALL produce none.
REQ-016 SHALL store characters in an 8-entry, 7-bit memory with 3-bit wr_ptr and rd_ptr.
REQ-017 On a write event with msg_len<8: mem[wr_ptr] <= seg_in as sampled in the event cycle, wr_ptr+1, msg_len+1, wr_ack=1 the following cycle.
REQ-018 On a write event with msg_len==8: no storage or pointer change, ovf=1 the following cycle, wr_ack stays 0.
REQ-019 On a clear event: msg_len, wr_ptr, rd_ptr <= 0; memory contents unchanged.
REQ-020 Clear and write events in the same cycle: clear wins, write discarded, no wr_ack, no ovf.
REQ-021 rd_req with msg_len>0: rd_data <= mem[rd_ptr], rd_valid=1 next cycle (latency 1); rd_ptr <= 0 if rd_ptr+1==msg_len, else rd_ptr+1.
REQ-022 rd_req with msg_len==0: rd_data <= 7'b1111111 (blank), rd_valid=1 next cycle, rd_ptr unchanged.
REQ-023 rd_req and write event same cycle: both execute; read uses pre-write msg_len and memory for data and wrap.
REQ-024 rd_req and clear event same cycle: rd_data blank, rd_valid=1, rd_ptr=0.
REQ-025 rd_data SHALL hold its value between reads; rd_valid, wr_ack, ovf SHALL never be high two consecutive cycles from one event.
REQ-026 msg_len, full, empty SHALL update in the cycle after the causing event.

Reset
REQ-027 While Resetn=0, independent of clock: rd_data=7'b1111111, rd_valid=0, msg_len=0, empty=1, full=0, wr_ack=0, ovf=0, pointers 0, debounce counters 0, synchronized and debounced key levels 1 (released).
REQ-028 Reset deasserted with a key held SHALL yield one press event after DB_CYCLES clocks; memory contents need not be reset.
REQ-029 Reset asserted mid-debounce or mid-read SHALL abort it; no pulse output after release until a new event.

Verification (DB_CYCLES=4 in bench)
REQ-030 Reset, then 3 writes with seg_in=7'b1001000,7'b0110000,7'b1110001 -> 3 wr_ack pulses, msg_len=3, empty=0.
REQ-031 Then 7 rd_req pulses -> rd_data sequence 1001000,0110000,1110001,1001000,0110000,1110001,1001000, each with one rd_valid.
REQ-032 wr_key_n glitch low 3 clocks then high -> no wr_ack; held low 20 clocks -> exactly one wr_ack.
REQ-033 9 writes from empty -> 8 wr_ack, 1 ovf, full=1, msg_len=8; 9th seg_in never read back.
REQ-034 Clear and write events same cycle with msg_len=5 -> msg_len=0, no wr_ack; subsequent rd_req -> rd_data=1111111, rd_valid=1.
REQ-035 Resetn pulsed low while msg_len=4 and wr_key_n held -> outputs at reset values; one wr_ack DB_CYCLES+3 clocks after release.

Source files
------------

// File: rtl/scroll_msg_loader.sv
// Scrolling-message character store: two debounced pushbuttons (append / clear)
// feed an 8-entry segment-code buffer that a scroller reads back in a circle.
module scroll_msg_loader #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [0:6] seg_in,
  input  logic       wr_key_n,
  input  logic       clr_key_n,
  input  logic       rd_req,
  output logic [0:6] rd_data,
  output logic       rd_valid,
  output logic [3:0] msg_len,
  output logic       full,
  output logic       empty,
  output logic       wr_ack,
  output logic       ovf
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
  localparam logic [0:6] Blank = 7'b1111111;

  // Bit 0: write key, bit 1: clear key.
  logic [1:0]      key_raw;
  logic [1:0]      sync1_q, sync2_q, db_q, press_q;
  logic [CntW-1:0] cnt_q [2];

  logic [0:6] mem_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic       wr_ev, clr_ev, do_write;

  assign key_raw  = {clr_key_n, wr_key_n};
  assign wr_ev    = press_q[0];
  assign clr_ev   = press_q[1];
  assign full     = (msg_len == 4'd8);
  assign empty    = (msg_len == 4'd0);
  // Clear wins over a coincident write.
  assign do_write = wr_ev & ~clr_ev & ~full;

  // Synchronize, debounce and edge-detect both keys; press_q is a one-cycle event.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      db_q     <= 2'b11;
      press_q  <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      press_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] != db_q[k]) begin
          if (cnt_q[k] == CntLast) begin
            db_q[k]    <= sync2_q[k];
            cnt_q[k]   <= '0;
            // Only the released->pressed transition is an event.
            press_q[k] <= ~sync2_q[k];
          end else begin
            cnt_q[k] <= cnt_q[k] + CntW'(1);
          end
        end else begin
          cnt_q[k] <= '0;
        end
      end
    end
  end

  // Character memory; contents survive reset and clear.
  always_ff @(posedge CLOCK_50) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= seg_in;
    end
  end

  // Buffer bookkeeping and read port; reads see pre-write length and memory.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      msg_len  <= 4'd0;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      rd_data  <= Blank;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      ovf      <= 1'b0;
      rd_valid <= rd_req;
      if (clr_ev) begin
        msg_len  <= 4'd0;
        wr_ptr_q <= 3'd0;
        rd_ptr_q <= 3'd0;
      end else if (wr_ev) begin
        if (!full) begin
          wr_ptr_q <= wr_ptr_q + 3'd1;
          msg_len  <= msg_len + 4'd1;
          wr_ack   <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
      if (rd_req) begin
        if (clr_ev || empty) begin
          rd_data <= Blank;
        end else begin
          rd_data  <= mem_q[rd_ptr_q];
          rd_ptr_q <= (({1'b0, rd_ptr_q} + 4'd1) == msg_len) ? 3'd0 : rd_ptr_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_msg_loader.sv
// Directed bench for scroll_msg_loader with a short debounce window.
module tb_scroll_msg_loader;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:6] seg_in;
  logic       wr_key_n, clr_key_n, rd_req;
  logic [0:6] rd_data;
  logic       rd_valid, full, empty, wr_ack, ovf;
  logic [3:0] msg_len;

  scroll_msg_loader #(.DB_CYCLES(DB)) dut (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .seg_in   (seg_in),
    .wr_key_n (wr_key_n),
    .clr_key_n(clr_key_n),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .msg_len  (msg_len),
    .full     (full),
    .empty    (empty),
    .wr_ack   (wr_ack),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Pulse counters, sampled on the falling edge.
  int ack_n = 0, ovf_n = 0, rdv_n = 0, dbl_n = 0;
  logic ack_prev = 1'b0, ovf_prev = 1'b0, rdv_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_ack) ack_n++;
    if (ovf) ovf_n++;
    if (rd_valid) rdv_n++;
    if ((wr_ack && ack_prev) || (ovf && ovf_prev)) dbl_n++;
    ack_prev = wr_ack;
    ovf_prev = ovf;
    rdv_prev = rd_valid;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic press(input logic do_wr, input logic do_clr, input logic [0:6] seg,
                       input int hold);
    seg_in = seg;
    if (do_wr) wr_key_n = 1'b0;
    if (do_clr) clr_key_n = 1'b0;
    repeat (hold) @(negedge clk);
    wr_key_n  = 1'b1;
    clr_key_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic read(input string name, input logic [0:6] exp);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check({name, "_data"}, 32'(rd_data), 32'(exp));
    @(negedge clk);
    check({name, "_valid_drop"}, 32'(rd_valid), 32'd0);
  endtask

  typedef struct {
    logic       is_write;
    logic [0:6] data;
    logic [3:0] exp_len;
  } op_t;

  op_t        ops [10];
  logic [0:6] nine [9];
  int         a0, o0;

  initial begin
    ops[0] = '{1'b1, 7'b1001000, 4'd1};
    ops[1] = '{1'b1, 7'b0110000, 4'd2};
    ops[2] = '{1'b1, 7'b1110001, 4'd3};
    ops[3] = '{1'b0, 7'b1001000, 4'd3};
    ops[4] = '{1'b0, 7'b0110000, 4'd3};
    ops[5] = '{1'b0, 7'b1110001, 4'd3};
    ops[6] = '{1'b0, 7'b1001000, 4'd3};
    ops[7] = '{1'b0, 7'b0110000, 4'd3};
    ops[8] = '{1'b0, 7'b1110001, 4'd3};
    ops[9] = '{1'b0, 7'b1001000, 4'd3};
    for (int i = 0; i < 9; i++) nine[i] = 7'(i * 13 + 5);

    rst_n = 1'b0; seg_in = '0; wr_key_n = 1'b1; clr_key_n = 1'b1; rd_req = 1'b0;
    #23;
    check("rst_rd_data", 32'(rd_data), 32'h7f);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_msg_len", 32'(msg_len), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three writes then seven circular reads.
    for (int i = 0; i < 10; i++) begin
      if (ops[i].is_write) begin
        a0 = ack_n;
        press(1'b1, 1'b0, ops[i].data, 10);
        check("wr_ack_count", 32'(ack_n - a0), 32'd1);
      end else begin
        read("circ_read", ops[i].data);
      end
      check("op_msg_len", 32'(msg_len), 32'(ops[i].exp_len));
    end
    check("len3_empty", 32'(empty), 32'd0);
    check("rdv_total", 32'(rdv_n), 32'd7);

    // Short glitch is filtered; a long hold yields a single write.
    a0 = ack_n;
    press(1'b1, 1'b0, 7'b0000001, 3);
    check("glitch_ack", 32'(ack_n - a0), 32'd0);
    check("glitch_len", 32'(msg_len), 32'd3);
    press(1'b1, 1'b0, 7'b0000001, 20);
    check("hold_ack", 32'(ack_n - a0), 32'd1);
    check("hold_len", 32'(msg_len), 32'd4);

    // Clear, then overflow with nine writes.
    press(1'b0, 1'b1, 7'b0, 10);
    check("clr_len", 32'(msg_len), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    a0 = ack_n; o0 = ovf_n;
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, nine[i], 10);
    check("ovf_acks", 32'(ack_n - a0), 32'd8);
    check("ovf_pulses", 32'(ovf_n - o0), 32'd1);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_len", 32'(msg_len), 32'd8);
    for (int i = 0; i < 8; i++) read("full_read", nine[i]);
    read("wrap_read", nine[0]);

    // Coincident clear and write with five stored characters.
    press(1'b0, 1'b1, 7'b0, 10);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, nine[i], 10);
    check("pre_both_len", 32'(msg_len), 32'd5);
    a0 = ack_n; o0 = ovf_n;
    press(1'b1, 1'b1, 7'b0101010, 10);
    check("both_len", 32'(msg_len), 32'd0);
    check("both_ack", 32'(ack_n - a0), 32'd0);
    check("both_ovf", 32'(ovf_n - o0), 32'd0);
    read("empty_read", 7'b1111111);

    // Reset during a held key, then one write DB+3 clocks after release.
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, nine[i], 10);
    check("pre_rst_len", 32'(msg_len), 32'd4);
    wr_key_n = 1'b0;
    repeat (3) @(negedge clk);
    rd_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_len", 32'(msg_len), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_rd_data", 32'(rd_data), 32'h7f);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("in_rst_ack", 32'(wr_ack), 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= int'(DB) + 3; e++) begin
      @(posedge clk);
      #1;
      check("post_rst_ack", 32'(wr_ack), (e == int'(DB) + 3) ? 32'd1 : 32'd0);
      check("post_rst_valid", 32'(rd_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    check("post_rst_ack_drop", 32'(wr_ack), 32'd0);
    check("post_rst_len", 32'(msg_len), 32'd1);
    wr_key_n = 1'b1;
    repeat (12) @(negedge clk);
    check("double_pulse", 32'(dbl_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
